// File: rtl/ice40_osc_rgb_model_pkg.sv
// rtl/ice40_osc_rgb_model_pkg.sv - shared constants and code helpers for the iCE40 osc/RGB model
package ice40_model_pkg;

    localparam int DIV_2   = 0;
    localparam int DIV_4   = 1;
    localparam int DIV_8   = 2;
    localparam int DIV_16  = 3;
    localparam int DIV_MAX = DIV_16;

    localparam int MA_PER_BIT_FULL = 4;
    localparam int MA_PER_BIT_HALF = 2;

    localparam int CNT_W = 16;

    // Thermometer form: once a zero is seen scanning upward, no ones may follow.
    function automatic logic is_thermo(input logic [5:0] code);
        logic seen_zero;
        is_thermo = 1'b1;
        seen_zero = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (!code[i]) begin
                seen_zero = 1'b1;
            end else if (seen_zero) begin
                is_thermo = 1'b0;
            end
        end
    endfunction

    function automatic logic [2:0] popcount6(input logic [5:0] v);
        popcount6 = 3'd0;
        for (int i = 0; i < 6; i++) begin
            popcount6 = popcount6 + {2'b00, v[i]};
        end
    endfunction

endpackage

// File: rtl/ice40_osc_rgb_model_if.sv
// rtl/ice40_osc_rgb_model_if.sv - control/status bundle between tiny_cpu glue and the osc/RGB model
interface ice40_osc_rgb_model_if;
    logic        clkhfpu;
    logic        clkhfen;
    logic        clkhf;
    logic        clkhf_ready;
    logic        rgbleden;
    logic        curren;
    logic [2:0]  rgb_pwm;
    logic [2:0]  rgb;
    logic [14:0] rgb_ma;
    logic        cfg_err;

    modport master (
        output clkhfpu, clkhfen, rgbleden, curren, rgb_pwm,
        input  clkhf, clkhf_ready, rgb, rgb_ma, cfg_err
    );

    modport slave (
        input  clkhfpu, clkhfen, rgbleden, curren, rgb_pwm,
        output clkhf, clkhf_ready, rgb, rgb_ma, cfg_err
    );
endinterface

// File: rtl/ice40_rgb_channel.sv
// rtl/ice40_rgb_channel.sv - one RGB current sink: registered active-low enable and mA report
module ice40_rgb_channel
    import ice40_model_pkg::*;
#(
    parameter bit HALF_MODE = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       pwm_i,
    input  logic [5:0] code_i,
    output logic       rgb_o,
    output logic [4:0] ma_o
);

    localparam logic [4:0] MA_PER_BIT = HALF_MODE ? 5'(MA_PER_BIT_HALF) : 5'(MA_PER_BIT_FULL);

    logic       on;
    logic [4:0] ma_on;
    logic       rgb_q, rgb_d;
    logic [4:0] ma_q, ma_d;

    always_comb begin
        on    = en_i & pwm_i & (code_i != 6'd0) & is_thermo(code_i);
        ma_on = {2'b00, popcount6(code_i)} * MA_PER_BIT;
        rgb_d = ~on;
        ma_d  = on ? ma_on : 5'd0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rgb_q <= 1'b1;
            ma_q  <= 5'd0;
        end else begin
            rgb_q <= rgb_d;
            ma_q  <= ma_d;
        end
    end

    assign rgb_o = rgb_q;
    assign ma_o  = ma_q;

endmodule

// File: rtl/ice40_osc_rgb_model.sv
// rtl/ice40_osc_rgb_model.sv - SB_HFOSC + SB_RGBA_DRV stand-in: settle counters, divider, sinks
module ice40_osc_rgb_model
    import ice40_model_pkg::*;
#(
    parameter int       CLKHF_DIV    = 0,
    parameter int       PU_DELAY     = 16,
    parameter int       CURREN_DELAY = 8,
    parameter logic [5:0] RGB0_CURRENT = 6'b000001,
    parameter logic [5:0] RGB1_CURRENT = 6'b000001,
    parameter logic [5:0] RGB2_CURRENT = 6'b000001,
    parameter bit       HALF_MODE    = 1'b0
) (
    input  logic int_osc,
    input  logic rst_n,
    ice40_osc_rgb_model_if.slave bus
);

    localparam logic DIV_OK  = (CLKHF_DIV >= 0) && (CLKHF_DIV <= DIV_MAX);
    localparam int   DIV_EFF = DIV_OK ? CLKHF_DIV : 0;
    localparam logic [2:0] HALF_M1 = 3'((1 << DIV_EFF) - 1);

    localparam logic [CNT_W-1:0] PU_SAT  = CNT_W'(PU_DELAY);
    localparam logic [CNT_W-1:0] CUR_SAT = CNT_W'(CURREN_DELAY);

    localparam logic [17:0] CODES = {RGB2_CURRENT, RGB1_CURRENT, RGB0_CURRENT};

    localparam logic CFG_ERR = !DIV_OK
                             || !is_thermo(RGB0_CURRENT)
                             || !is_thermo(RGB1_CURRENT)
                             || !is_thermo(RGB2_CURRENT);

    logic [CNT_W-1:0] pu_cnt_q, pu_cnt_d;
    logic [CNT_W-1:0] cur_cnt_q, cur_cnt_d;
    logic [2:0]       div_cnt_q, div_cnt_d;
    logic             clkhf_q, clkhf_d;

    logic ready;
    logic curren_ok;
    logic run;
    logic led_en;

    assign ready     = (pu_cnt_q == PU_SAT);
    assign curren_ok = (cur_cnt_q == CUR_SAT);
    // clkhfpu is included directly so a power-down stops clkhf on the same edge that drops ready.
    assign run       = DIV_OK & bus.clkhfpu & bus.clkhfen & ready;
    assign led_en    = bus.rgbleden & curren_ok;

    always_comb begin
        pu_cnt_d  = '0;
        cur_cnt_d = '0;
        div_cnt_d = 3'd0;
        clkhf_d   = 1'b0;

        if (bus.clkhfpu) begin
            pu_cnt_d = ready ? pu_cnt_q : pu_cnt_q + 1'b1;
        end

        if (bus.curren) begin
            cur_cnt_d = curren_ok ? cur_cnt_q : cur_cnt_q + 1'b1;
        end

        if (run) begin
            if (div_cnt_q == HALF_M1) begin
                div_cnt_d = 3'd0;
                clkhf_d   = ~clkhf_q;
            end else begin
                div_cnt_d = div_cnt_q + 3'd1;
                clkhf_d   = clkhf_q;
            end
        end
    end

    always_ff @(posedge int_osc or negedge rst_n) begin
        if (!rst_n) begin
            pu_cnt_q  <= '0;
            cur_cnt_q <= '0;
            div_cnt_q <= 3'd0;
            clkhf_q   <= 1'b0;
        end else begin
            pu_cnt_q  <= pu_cnt_d;
            cur_cnt_q <= cur_cnt_d;
            div_cnt_q <= div_cnt_d;
            clkhf_q   <= clkhf_d;
        end
    end

    logic [2:0]  rgb_w;
    logic [14:0] ma_w;

    for (genvar i = 0; i < 3; i++) begin : g_ch
        ice40_rgb_channel #(
            .HALF_MODE(HALF_MODE)
        ) u_ch (
            .clk_i  (int_osc),
            .rst_ni (rst_n),
            .en_i   (led_en),
            .pwm_i  (bus.rgb_pwm[i]),
            .code_i (CODES[6*i +: 6]),
            .rgb_o  (rgb_w[i]),
            .ma_o   (ma_w[5*i +: 5])
        );
    end

    assign bus.clkhf       = clkhf_q;
    assign bus.clkhf_ready = ready;
    assign bus.rgb         = rgb_w;
    assign bus.rgb_ma      = ma_w;
    assign bus.cfg_err     = CFG_ERR;

endmodule

// File: tb/tb_ice40_osc_rgb_model.sv
// tb/tb_ice40_osc_rgb_model.sv - randomized check of three model configurations against a behavioural reference
module tb_ice40_osc_rgb_model;

    localparam int N = 3;
    localparam int PU_P   [N] = '{4, 2, 1};
    localparam int DIV_P  [N] = '{1, 0, 5};
    localparam int CD_P   [N] = '{3, 5, 1};
    localparam int HALF_P [N] = '{0, 1, 0};
    localparam logic [5:0] CODE_P [N][3] = '{
        '{6'b000001, 6'b000001, 6'b000001},
        '{6'b000111, 6'b000101, 6'b111111},
        '{6'b000011, 6'b000000, 6'b001111}
    };

    logic int_osc = 1'b0;
    logic rst_n;
    always #5 int_osc = ~int_osc;

    logic       pu, en, leden, cur;
    logic [2:0] pwm;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    ice40_osc_rgb_model_if if_a ();
    ice40_osc_rgb_model_if if_b ();
    ice40_osc_rgb_model_if if_c ();

    assign if_a.clkhfpu = pu;  assign if_a.clkhfen = en;  assign if_a.rgbleden = leden;
    assign if_a.curren = cur;  assign if_a.rgb_pwm = pwm;
    assign if_b.clkhfpu = pu;  assign if_b.clkhfen = en;  assign if_b.rgbleden = leden;
    assign if_b.curren = cur;  assign if_b.rgb_pwm = pwm;
    assign if_c.clkhfpu = pu;  assign if_c.clkhfen = en;  assign if_c.rgbleden = leden;
    assign if_c.curren = cur;  assign if_c.rgb_pwm = pwm;

    ice40_osc_rgb_model #(
        .CLKHF_DIV(1), .PU_DELAY(4), .CURREN_DELAY(3),
        .RGB0_CURRENT(6'b000001), .RGB1_CURRENT(6'b000001), .RGB2_CURRENT(6'b000001),
        .HALF_MODE(1'b0)
    ) dut_a (.int_osc(int_osc), .rst_n(rst_n), .bus(if_a));

    ice40_osc_rgb_model #(
        .CLKHF_DIV(0), .PU_DELAY(2), .CURREN_DELAY(5),
        .RGB0_CURRENT(6'b000111), .RGB1_CURRENT(6'b000101), .RGB2_CURRENT(6'b111111),
        .HALF_MODE(1'b1)
    ) dut_b (.int_osc(int_osc), .rst_n(rst_n), .bus(if_b));

    ice40_osc_rgb_model #(
        .CLKHF_DIV(5), .PU_DELAY(1), .CURREN_DELAY(1),
        .RGB0_CURRENT(6'b000011), .RGB1_CURRENT(6'b000000), .RGB2_CURRENT(6'b001111),
        .HALF_MODE(1'b0)
    ) dut_c (.int_osc(int_osc), .rst_n(rst_n), .bus(if_c));

    logic        clkhf_w [N];
    logic        rdy_w   [N];
    logic [2:0]  rgb_w   [N];
    logic [14:0] ma_w    [N];
    logic        err_w   [N];

    assign clkhf_w[0] = if_a.clkhf;  assign rdy_w[0] = if_a.clkhf_ready;  assign rgb_w[0] = if_a.rgb;
    assign ma_w[0] = if_a.rgb_ma;    assign err_w[0] = if_a.cfg_err;
    assign clkhf_w[1] = if_b.clkhf;  assign rdy_w[1] = if_b.clkhf_ready;  assign rgb_w[1] = if_b.rgb;
    assign ma_w[1] = if_b.rgb_ma;    assign err_w[1] = if_b.cfg_err;
    assign clkhf_w[2] = if_c.clkhf;  assign rdy_w[2] = if_c.clkhf_ready;  assign rgb_w[2] = if_c.rgb;
    assign ma_w[2] = if_c.rgb_ma;    assign err_w[2] = if_c.cfg_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit thermo_ok(input logic [5:0] code);
        logic [6:0] c;
        c = {1'b0, code};
        return ((c + 7'd1) & c) == 7'd0;
    endfunction

    // Reference: run lengths of consecutive enabled edges, outputs derived arithmetically.
    int          pu_len  [N];
    int          run_len [N];
    int          cur_len [N];
    logic        m_clkhf [N];
    logic        m_rdy   [N];
    logic [2:0]  m_rgb   [N];
    logic [14:0] m_ma    [N];

    int          t_pu, t_run, t_cur, t_half;
    bit          t_ready_old, t_ok_old, t_run_now, t_lit;
    logic [2:0]  t_rgb;
    logic [14:0] t_ma;

    always @(posedge int_osc or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                pu_len[k]  <= 0;
                run_len[k] <= 0;
                cur_len[k] <= 0;
                m_clkhf[k] <= 1'b0;
                m_rdy[k]   <= 1'b0;
                m_rgb[k]   <= 3'b111;
                m_ma[k]    <= 15'd0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                t_ready_old = pu_len[k] >= PU_P[k];
                t_ok_old    = cur_len[k] >= CD_P[k];
                t_run_now   = pu && en && t_ready_old;
                t_pu  = pu  ? ((pu_len[k] + 1 > PU_P[k]) ? PU_P[k] : pu_len[k] + 1) : 0;
                t_cur = cur ? ((cur_len[k] + 1 > CD_P[k]) ? CD_P[k] : cur_len[k] + 1) : 0;
                t_run = t_run_now ? run_len[k] + 1 : 0;
                t_half = 1 << (DIV_P[k] & 3);
                t_rgb = 3'b111;
                t_ma  = 15'd0;
                for (int ch = 0; ch < 3; ch++) begin
                    t_lit = leden && t_ok_old && pwm[ch] && (CODE_P[k][ch] != 6'd0) && thermo_ok(CODE_P[k][ch]);
                    t_rgb[ch] = ~t_lit;
                    t_ma[5*ch +: 5] = t_lit ? 5'($countones(CODE_P[k][ch]) * (HALF_P[k] != 0 ? 2 : 4)) : 5'd0;
                end
                pu_len[k]  <= t_pu;
                cur_len[k] <= t_cur;
                run_len[k] <= t_run;
                m_rdy[k]   <= (t_pu >= PU_P[k]);
                m_clkhf[k] <= (DIV_P[k] <= 3 && t_run > 0) ? (((t_run / t_half) % 2) == 1) : 1'b0;
                m_rgb[k]   <= t_rgb;
                m_ma[k]    <= t_ma;
            end
        end
    end

    always @(negedge int_osc) begin
        if (chk_en) begin
            for (int k = 0; k < N; k++) begin
                check($sformatf("clkhf[%0d]", k), 32'(clkhf_w[k]), 32'(m_clkhf[k]));
                check($sformatf("ready[%0d]", k), 32'(rdy_w[k]), 32'(m_rdy[k]));
                check($sformatf("rgb[%0d]", k), 32'(rgb_w[k]), 32'(m_rgb[k]));
                check($sformatf("rgb_ma[%0d]", k), 32'(ma_w[k]), 32'(m_ma[k]));
                check($sformatf("cfg_err[%0d]", k), 32'(err_w[k]),
                      32'(DIV_P[k] > 3 || !thermo_ok(CODE_P[k][0]) || !thermo_ok(CODE_P[k][1])
                          || !thermo_ok(CODE_P[k][2])));
            end
        end
    end

    logic [12:1] clk_exp_a;

    initial begin
        pu = 1'b1; en = 1'b1; leden = 1'b1; cur = 1'b1; pwm = 3'b111;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge int_osc);
        check("rst_rgb_a", 32'(if_a.rgb), 32'h7);
        check("rst_clkhf_a", 32'(if_a.clkhf), 32'h0);
        check("rst_ready_a", 32'(if_a.clkhf_ready), 32'h0);
        check("rst_ma_a", 32'(if_a.rgb_ma), 32'h0);
        check("rst_rgb_b", 32'(if_b.rgb), 32'h7);
        check("rst_ma_b", 32'(if_b.rgb_ma), 32'h0);
        chk_en = 1'b1;

        #1;
        pwm = 3'b101;
        rst_n = 1'b1;
        clk_exp_a = 12'b011001100000;
        for (int e = 1; e <= 12; e++) begin
            @(negedge int_osc);
            check($sformatf("lit_ready_a_e%0d", e), 32'(if_a.clkhf_ready), 32'(e >= 4));
            check($sformatf("lit_rgb_a_e%0d", e), 32'(if_a.rgb), (e >= 4) ? 32'h2 : 32'h7);
            check($sformatf("lit_clkhf_a_e%0d", e), 32'(if_a.clkhf), 32'(clk_exp_a[e]));
        end
        check("lit_ma_a", 32'(if_a.rgb_ma), 32'd4100);
        check("lit_ma_b", 32'(if_b.rgb_ma), 32'd12294);
        check("lit_rgb_b", 32'(if_b.rgb), 32'h2);
        check("lit_err_a", 32'(if_a.cfg_err), 32'h0);
        check("lit_err_b", 32'(if_b.cfg_err), 32'h1);
        check("lit_err_c", 32'(if_c.cfg_err), 32'h1);
        check("lit_clkhf_c", 32'(if_c.clkhf), 32'h0);

        repeat (2) @(negedge int_osc);
        check("drop_pre_clkhf_a", 32'(if_a.clkhf), 32'h1);
        #1 pu = 1'b0;
        @(negedge int_osc);
        check("drop_ready_a", 32'(if_a.clkhf_ready), 32'h0);
        check("drop_clkhf_a", 32'(if_a.clkhf), 32'h0);
        #1 pu = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(negedge int_osc);
            check($sformatf("restart_ready_a_e%0d", e), 32'(if_a.clkhf_ready), 32'(e >= 4));
        end

        #1 pwm = 3'b010;
        @(negedge int_osc);
        check("illegal_rgb_b", 32'(if_b.rgb), 32'h7);
        check("illegal_ma_b", 32'(if_b.rgb_ma), 32'h0);
        check("ch1_ma_a", 32'(if_a.rgb_ma), 32'd128);

        repeat (3000) begin
            #1;
            if ($urandom_range(0, 19) == 0) pu = ~pu;
            if ($urandom_range(0, 9) == 0)  en = ~en;
            if ($urandom_range(0, 9) == 0)  leden = ~leden;
            if ($urandom_range(0, 24) == 0) cur = ~cur;
            if ($urandom_range(0, 3) == 0)  pwm = 3'($urandom);
            @(negedge int_osc);
        end

        #1;
        pu = 1'b1; en = 1'b1; leden = 1'b1; cur = 1'b1; pwm = 3'b111;
        repeat (8) @(negedge int_osc);
        check("pre_async_rgb_a", 32'(if_a.rgb), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rgb_a", 32'(if_a.rgb), 32'h7);
        check("async_rgb_b", 32'(if_b.rgb), 32'h7);
        check("async_ma_a", 32'(if_a.rgb_ma), 32'h0);
        check("async_clkhf_a", 32'(if_a.clkhf), 32'h0);
        check("async_ready_a", 32'(if_a.clkhf_ready), 32'h0);
        @(negedge int_osc);
        #1 rst_n = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(negedge int_osc);
            check($sformatf("relight_rgb_a_e%0d", e), 32'(if_a.rgb), (e >= 4) ? 32'h0 : 32'h7);
        end

        repeat (2) @(negedge int_osc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
